// File: rtl/async_fifo.sv
// Gray-pointer FIFO with 2-flop pointer synchronizers, run from a single clock.
// Full/empty flags are registered and conservative: they may lag real occupancy by up to three edges.
module async_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int PTR_W  = ADDR_W + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WINC,
   input  logic [WIDTH-1:0] WDATA,
   output logic             WFULL,
   input  logic             RINC,
   output logic [WIDTH-1:0] RDATA,
   output logic             REMPTY
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wbin_q, wbin_d, wgray_q, wgray_d;
   logic [PTR_W-1:0]  rbin_q, rbin_d, rgray_q, rgray_d;
   logic [PTR_W-1:0]  wq1_rgray_side_q, wq2_rgray_side_q;
   logic [PTR_W-1:0]  rq1_wgray_side_q, rq2_wgray_side_q;
   logic              wfull_q, wfull_d, rempty_q, rempty_d;
   logic              winc_ok_s, rinc_ok_s;
   logic [PTR_W-1:0]  full_cmp_s;

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Next-state pointers and flag terms for both sides.
   always_comb begin
      winc_ok_s  = WINC & ~wfull_q;
      rinc_ok_s  = RINC & ~rempty_q;
      wbin_d     = wbin_q + {{(PTR_W-1){1'b0}}, winc_ok_s};
      rbin_d     = rbin_q + {{(PTR_W-1){1'b0}}, rinc_ok_s};
      wgray_d    = bin2gray(wbin_d);
      rgray_d    = bin2gray(rbin_d);
      // Full when the write pointer is a whole lap ahead: top two Gray bits inverted.
      full_cmp_s = {~rq2_wgray_side_q[PTR_W-1:PTR_W-2], rq2_wgray_side_q[PTR_W-3:0]};
      wfull_d    = (wgray_d == full_cmp_s);
      rempty_d   = (rgray_d == wq2_rgray_side_q);
   end

   // Pointer, synchronizer and flag registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wbin_q           <= {PTR_W{1'b0}};
         wgray_q          <= {PTR_W{1'b0}};
         rbin_q           <= {PTR_W{1'b0}};
         rgray_q          <= {PTR_W{1'b0}};
         wq1_rgray_side_q <= {PTR_W{1'b0}};
         wq2_rgray_side_q <= {PTR_W{1'b0}};
         rq1_wgray_side_q <= {PTR_W{1'b0}};
         rq2_wgray_side_q <= {PTR_W{1'b0}};
         wfull_q          <= 1'b0;
         rempty_q         <= 1'b1;
      end else begin
         wbin_q           <= wbin_d;
         wgray_q          <= wgray_d;
         rbin_q           <= rbin_d;
         rgray_q          <= rgray_d;
         wq1_rgray_side_q <= wgray_q;
         wq2_rgray_side_q <= wq1_rgray_side_q;
         rq1_wgray_side_q <= rgray_q;
         rq2_wgray_side_q <= rq1_wgray_side_q;
         wfull_q          <= wfull_d;
         rempty_q         <= rempty_d;
      end
   end

   // Storage array; cleared on reset so the head reads zero.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (winc_ok_s) begin
         mem_q[wbin_q[ADDR_W-1:0]] <= WDATA;
      end else begin
         mem_q[wbin_q[ADDR_W-1:0]] <= mem_q[wbin_q[ADDR_W-1:0]];
      end
   end

   assign RDATA  = mem_q[rbin_q[ADDR_W-1:0]];
   assign WFULL  = wfull_q;
   assign REMPTY = rempty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo: reset, fill, concurrent traffic,
// drain, overflow, full release with pointer wrap, and reset mid-operation.
module tb_async_fifo;

   logic       CLK, RST, WINC, RINC, WFULL, REMPTY;
   logic [7:0] WDATA, RDATA;
   int         tests = 0;
   int         fails = 0;

   async_fifo #(.WIDTH(8), .DEPTH(16)) dut (
      .CLK(CLK), .RST(RST), .WINC(WINC), .WDATA(WDATA), .WFULL(WFULL),
      .RINC(RINC), .RDATA(RDATA), .REMPTY(REMPTY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b1; WINC = 1'b0; RINC = 1'b0; WDATA = 8'd0;
      repeat (5) tick();
      chk("rst_empty", 32'(REMPTY), 32'd1);
      chk("rst_full",  32'(WFULL),  32'd0);
      chk("rst_rdata", 32'(RDATA),  32'd0);

      // Underflow attempt: must be ignored.
      RST = 1'b0; RINC = 1'b1; tick(); RINC = 1'b0;
      chk("underflow_empty", 32'(REMPTY), 32'd1);
      chk("underflow_rdata", 32'(RDATA),  32'd0);

      // Fill to half: REMPTY falls 3 edges after the first write.
      for (int i = 0; i < 8; i++) begin
         WINC = 1'b1; WDATA = 8'(i); tick();
         chk("fill_empty", 32'(REMPTY), 32'(i < 3));
         chk("fill_full",  32'(WFULL),  32'd0);
      end
      WINC = 1'b0;
      chk("fill_head", 32'(RDATA), 32'd0);

      // Concurrent write/read keeps occupancy at 8.
      for (int i = 8; i < 16; i++) begin
         WINC = 1'b1; WDATA = 8'(i); RINC = 1'b1;
         chk("conc_head", 32'(RDATA), 32'(i - 8));
         tick();
         chk("conc_full",  32'(WFULL),  32'd0);
         chk("conc_empty", 32'(REMPTY), 32'd0);
      end
      WINC = 1'b0; RINC = 1'b0;
      chk("conc_after", 32'(RDATA), 32'd8);

      // Drain with extra reads: empty asserts on the edge popping the last word.
      RINC = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k < 8) chk("drain_data", 32'(RDATA), 32'(8 + k));
         tick();
         chk("drain_empty", 32'(REMPTY), 32'(k >= 7));
      end
      RINC = 1'b0;
      chk("drain_rdata", 32'(RDATA), 32'd0);

      // Overflow: full on the 16th write, later writes dropped.
      for (int i = 0; i < 32; i++) begin
         WINC = 1'b1; WDATA = 8'(i); tick();
         chk("ovf_full",  32'(WFULL),  32'(i >= 15));
         chk("ovf_empty", 32'(REMPTY), 32'(i < 3));
      end
      WINC = 1'b0;
      chk("ovf_head", 32'(RDATA), 32'd0);

      // Full release: one read, WFULL falls 3 edges later.
      RINC = 1'b1; tick(); RINC = 1'b0;
      chk("rel_full0", 32'(WFULL), 32'd1);
      tick(); chk("rel_full1", 32'(WFULL), 32'd1);
      tick(); chk("rel_full2", 32'(WFULL), 32'd1);
      tick(); chk("rel_full3", 32'(WFULL), 32'd0);
      chk("rel_head", 32'(RDATA), 32'd1);

      // Wrapped write refills to 16 entries.
      WINC = 1'b1; WDATA = 8'd99; tick(); WINC = 1'b0;
      chk("wrap_full", 32'(WFULL), 32'd1);
      RINC = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("wrap_data", 32'(RDATA), (k < 15) ? 32'(k + 1) : 32'd99);
         tick();
      end
      chk("wrap_empty", 32'(REMPTY), 32'd1);
      tick();
      chk("wrap_extra_empty", 32'(REMPTY), 32'd1);
      chk("wrap_extra_rdata", 32'(RDATA),  32'd1);
      RINC = 1'b0;

      // Reset mid-operation discards contents.
      for (int i = 0; i < 5; i++) begin
         WINC = 1'b1; WDATA = 8'(8'hA0 + i); tick();
      end
      WINC = 1'b0;
      chk("pre_rst_empty", 32'(REMPTY), 32'd0);
      chk("pre_rst_rdata", 32'(RDATA),  32'hA0);
      RST = 1'b1; tick(); RST = 1'b0;
      chk("mid_rst_empty", 32'(REMPTY), 32'd1);
      chk("mid_rst_full",  32'(WFULL),  32'd0);
      chk("mid_rst_rdata", 32'(RDATA),  32'd0);
      repeat (4) tick();
      chk("post_rst_empty", 32'(REMPTY), 32'd1);

      // Pointers restart at zero after reset.
      WINC = 1'b1; WDATA = 8'h5A; tick(); WINC = 1'b0;
      tick(); tick();
      chk("post_rst_empty_hold", 32'(REMPTY), 32'd1);
      tick();
      chk("post_rst_empty_fall", 32'(REMPTY), 32'd0);
      chk("post_rst_rdata",      32'(RDATA),  32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
